// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes,
// the sequencer state encoding and operand-signedness helpers.
package mdu_pkg;

  // funct7 value that marks an R-type as an M-extension instruction
  localparam logic [6:0] MDU_FUNCT7 = 7'b0000001;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_e;

  // rs1 is treated as two's complement for MULH, MULHSU, DIV and REM
  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  // rs2 is treated as two's complement for MULH, DIV and REM
  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: shift-add for multiply (accumulator shifts right),
// restoring shift-subtract for divide (accumulator = {remainder, quotient}).
module mdu_iter_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      is_div_s,
  input  logic [2*DATA_WIDTH-1:0]   acc_s,
  input  logic [DATA_WIDTH-1:0]     operand_s,
  output logic [2*DATA_WIDTH-1:0]   acc_next_s
);

  localparam int W = DATA_WIDTH;

  logic [W:0] sum_s;
  logic [W:0] rem_sh_s;
  logic [W:0] diff_s;

  // Single add/shift or subtract/shift step, chosen by operation class
  always_comb begin
    sum_s      = {1'b0, acc_s[2*W-1:W]} + {1'b0, operand_s};
    rem_sh_s   = acc_s[2*W-1:W-1];
    diff_s     = rem_sh_s - {1'b0, operand_s};
    acc_next_s = acc_s;
    if (is_div_s) begin
      // A clear top bit means the trial subtraction did not go negative
      if (!diff_s[W]) begin
        acc_next_s = {diff_s[W-1:0], acc_s[W-2:0], 1'b1};
      end else begin
        acc_next_s = {rem_sh_s[W-1:0], acc_s[W-2:0], 1'b0};
      end
    end else begin
      // Carry out of the upper-half add becomes the new MSB after the shift
      if (acc_s[0]) begin
        acc_next_s = {sum_s, acc_s[W-1:1]};
      end else begin
        acc_next_s = {1'b0, acc_s[2*W-1:1]};
      end
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide controller: captures one op, prepares
// operand magnitudes, runs DATA_WIDTH radix-2 steps, fixes the sign and
// presents a registered result with a one-cycle done pulse.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  mdu_state_e           state_r, state_next_s;
  logic [2:0]           op_r, op_next_s;
  logic [W-1:0]         rs1_r, rs1_next_s;
  logic [W-1:0]         rs2_r, rs2_next_s;
  logic [W-1:0]         oper_r, oper_next_s;
  logic [2*W-1:0]       acc_r, acc_next_s;
  logic                 neg_r, neg_next_s;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_next_s;
  logic [W-1:0]         result_r, result_next_s;
  logic                 busy_r, done_r;

  logic                 is_div_s, neg_a_s, neg_b_s, div_zero_s, overflow_s;
  logic [W-1:0]         mag_a_s, mag_b_s, quot_s, rem_s;
  logic [2*W-1:0]       prod_s, step_acc_s;

  mdu_iter_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .is_div_s   (is_div_s),
    .acc_s      (acc_r),
    .operand_s  (oper_r),
    .acc_next_s (step_acc_s)
  );

  // Next-state and datapath-update logic for the sequencer
  always_comb begin
    state_next_s  = state_r;
    op_next_s     = op_r;
    rs1_next_s    = rs1_r;
    rs2_next_s    = rs2_r;
    oper_next_s   = oper_r;
    acc_next_s    = acc_r;
    neg_next_s    = neg_r;
    cnt_next_s    = cnt_r;
    result_next_s = result_r;

    is_div_s   = op_r[2];
    neg_a_s    = rs1_signed(op_r) & rs1_r[W-1];
    neg_b_s    = rs2_signed(op_r) & rs2_r[W-1];
    mag_a_s    = neg_a_s ? -rs1_r : rs1_r;
    mag_b_s    = neg_b_s ? -rs2_r : rs2_r;
    div_zero_s = is_div_s && (rs2_r == {W{1'b0}});
    overflow_s = ((op_r == MDU_DIV) || (op_r == MDU_REM)) &&
                 (rs1_r == {1'b1, {(W-1){1'b0}}}) && (rs2_r == {W{1'b1}});
    prod_s     = neg_r ? -acc_r : acc_r;
    quot_s     = neg_r ? -acc_r[W-1:0] : acc_r[W-1:0];
    rem_s      = neg_r ? -acc_r[2*W-1:W] : acc_r[2*W-1:W];

    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          op_next_s    = funct3_i;
          rs1_next_s   = rs1_data_i;
          rs2_next_s   = rs2_data_i;
          state_next_s = ST_PREP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PREP: begin
        if (div_zero_s) begin
          // op_r[1] distinguishes REM/REMU from DIV/DIVU
          result_next_s = op_r[1] ? rs1_r : {W{1'b1}};
          state_next_s  = ST_DONE;
        end else if (overflow_s) begin
          result_next_s = op_r[1] ? {W{1'b0}} : rs1_r;
          state_next_s  = ST_DONE;
        end else begin
          cnt_next_s = {CNT_WIDTH{1'b0}};
          if (is_div_s) begin
            oper_next_s = mag_b_s;
            acc_next_s  = {{W{1'b0}}, mag_a_s};
            neg_next_s  = op_r[1] ? neg_a_s : (neg_a_s ^ neg_b_s);
          end else begin
            oper_next_s = mag_a_s;
            acc_next_s  = {{W{1'b0}}, mag_b_s};
            neg_next_s  = neg_a_s ^ neg_b_s;
          end
          state_next_s = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_next_s = step_acc_s;
        cnt_next_s = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          state_next_s = ST_FIX;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_FIX: begin
        case (op_r)
          MDU_MUL:                        result_next_s = prod_s[W-1:0];
          MDU_MULH, MDU_MULHSU, MDU_MULHU: result_next_s = prod_s[2*W-1:W];
          MDU_DIV, MDU_DIVU:              result_next_s = quot_s;
          MDU_REM, MDU_REMU:              result_next_s = rem_s;
          default:                        result_next_s = {W{1'b0}};
        endcase
        state_next_s = ST_DONE;
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      op_r     <= 3'b000;
      rs1_r    <= {W{1'b0}};
      rs2_r    <= {W{1'b0}};
      oper_r   <= {W{1'b0}};
      acc_r    <= {(2*W){1'b0}};
      neg_r    <= 1'b0;
      cnt_r    <= {CNT_WIDTH{1'b0}};
      result_r <= {W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      op_r     <= op_next_s;
      rs1_r    <= rs1_next_s;
      rs2_r    <= rs2_next_s;
      oper_r   <= oper_next_s;
      acc_r    <= acc_next_s;
      neg_r    <= neg_next_s;
      cnt_r    <= cnt_next_s;
      result_r <= result_next_s;
      busy_r   <= (state_next_s != ST_IDLE);
      done_r   <= (state_next_s == ST_DONE);
    end
  end

  assign busy_o   = busy_r;
  assign done_o   = done_r;
  assign result_o = result_r;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed vectors, reset abort,
// ignored start while busy, and random ops against a 64-bit arithmetic model.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  mdu_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .funct3_i   (funct3_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result straight from RV32M arithmetic rules
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] uprod;
    longint      sa, sb, ua, sprod;
    uprod = {32'h0, a} * {32'h0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, b});
    case (op)
      MDU_MUL:    return uprod[31:0];
      MDU_MULH:   begin sprod = sa * sb; return sprod[63:32]; end
      MDU_MULHSU: begin sprod = sa * ua; return sprod[63:32]; end
      MDU_MULHU:  return uprod[63:32];
      MDU_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      MDU_REM: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      MDU_DIVU: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      default:  return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  // Expected start-to-done distance in cycles
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 3'd4 && b == 32'h0) return 2;
    if ((op == MDU_DIV || op == MDU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 35;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the unit idle; spur_k > 0 pulses start_i at that cycle offset
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int spur_k);
    logic [31:0] exp;
    int          exp_lat;
    int          k;
    bit          busy_ok;
    exp     = ref_result(op, a, b);
    exp_lat = ref_latency(op, a, b);
    funct3_i   = op;
    rs1_data_i = a;
    rs2_data_i = b;
    start_i    = 1'b1;
    @(negedge clk);
    start_i    = 1'b0;
    funct3_i   = 3'($urandom);
    rs1_data_i = $urandom;
    rs2_data_i = $urandom;
    k       = 1;
    busy_ok = 1'b1;
    while (done_o !== 1'b1 && k < 64) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      if (k == spur_k) start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      k++;
    end
    if (busy_o !== 1'b1) busy_ok = 1'b0;
    check({tag, "_latency"}, 32'(k), 32'(exp_lat));
    check({tag, "_busy"}, {31'h0, busy_ok}, 32'h1);
    check({tag, "_result"}, result_o, exp);
    @(negedge clk);
    check({tag, "_idle"}, {30'h0, busy_o, done_o}, 32'h0);
  endtask

  initial begin
    bit seen_done;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    reset      = 1'b1;
    start_i    = 1'b0;
    funct3_i   = 3'b000;
    rs1_data_i = 32'h0;
    rs2_data_i = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy_o, done_o, result_o[29:0]}, 32'h0);
    check("reset_result", result_o, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mul_neg",   MDU_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 0);
    run_op("mulh_min",  MDU_MULH,   32'h8000_0000, 32'h8000_0000, 0);
    run_op("mulhu_max", MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulhsu",    MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div_m7",    MDU_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op("rem_m7",    MDU_REM,    32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op("divu_m7",   MDU_DIVU,   32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op("divu_zero", MDU_DIVU,   32'h0000_0005, 32'h0000_0000, 0);
    run_op("rem_zero",  MDU_REM,    32'h0000_0005, 32'h0000_0000, 0);
    run_op("div_ovf",   MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf",   MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("remu_big",  MDU_REMU,   32'hFFFF_FFFF, 32'h0001_0003, 0);
    run_op("mul_spur",  MDU_MUL,    32'h1234_5678, 32'h9ABC_DEF1, 5);

    // Reset mid-divide: outputs clear on the next cycle and no done follows
    funct3_i   = MDU_DIV;
    rs1_data_i = 32'h0000_0064;
    rs2_data_i = 32'h0000_0007;
    start_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'h0, busy_o}, 32'h0);
    check("abort_done", {31'h0, done_o}, 32'h0);
    check("abort_result", result_o, 32'h0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o === 1'b1) seen_done = 1'b1;
    end
    check("abort_no_done", {31'h0, seen_done}, 32'h0);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom);
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if (i == 3) begin
        rop = MDU_REM;
        ra  = 32'h8000_0000;
        rb  = 32'hFFFF_FFFF;
      end
      run_op("random", rop, ra, rb, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
